// File: rtl/md5_msg_padder.sv
// MD5 single-block message padder between the hash-search controller and the MD5 round core.
// Optional `MD5_PAD_WIDTH_CHECK_EN adds o_msg_err and rejects bad widths instead of clamping.
// Bit order: msg_in holds the W-bit message in bits [W-1:0], first byte most significant;
// block byte k sits at o_block_out[511-8k -: 8], so byte 0 is the top byte.

module md5_msg_padder #(
  parameter int unsigned MAX_BYTES = 16
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic [127:0] i_msg_in,
  input  logic [7:0]   i_msg_in_width,
  input  logic         i_msg_in_valid,
  output logic         o_ready,
  output logic [511:0] o_block_out,
  output logic         o_block_valid,
  input  logic         i_core_ready,
  input  logic [127:0] i_core_digest,
  input  logic         i_core_digest_valid,
  output logic [127:0] o_msg_output,
`ifdef MD5_PAD_WIDTH_CHECK_EN
  output logic         o_msg_err,
`endif
  output logic         o_msg_out_valid
);

  localparam logic [7:0] MaxW = 8'(MAX_BYTES * 8);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e         r_state;
  state_e         w_state_next;
  logic [511:0]   r_block;
  logic [127:0]   r_msg_output;
  logic [511:0]   w_block;
  logic [7:0]     w_width_eff;
  logic [7:0]     w_shift;
  logic [4:0]     w_nbytes;
  logic [127:0]   w_msg_aligned;
  logic           w_accept;
  logic           w_build;

  assign w_accept = i_msg_in_valid && (r_state == StIdle);

`ifdef MD5_PAD_WIDTH_CHECK_EN
  logic w_width_bad;
  logic r_msg_err;

  assign w_width_bad = (i_msg_in_width > MaxW) || (i_msg_in_width[2:0] != 3'b000);
  assign w_build     = w_accept && !w_width_bad;
  assign o_msg_err   = r_msg_err;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_msg_err <= 1'b0;
    end else begin
      r_msg_err <= w_accept && w_width_bad;
    end
  end
`else
  assign w_build = w_accept;
`endif

  // Clamp to MAX_BYTES and drop partial bytes; the clamped value is also the length field.
  always_comb begin
    w_width_eff = i_msg_in_width;
    if (i_msg_in_width > MaxW) begin
      w_width_eff = MaxW;
    end
    w_width_eff[2:0] = 3'b000;
  end

  assign w_nbytes      = w_width_eff[7:3];
  assign w_shift       = 8'd128 - w_width_eff;
  // Left-align so message byte 0 lands in the top byte; bits beyond W shift out as zeros.
  assign w_msg_aligned = i_msg_in << w_shift;

  always_comb begin
    w_block          = '0;
    w_block[511 -: 128] = w_msg_aligned;
    for (int k = 0; k <= 16; k++) begin
      if (w_nbytes == 5'(k)) begin
        w_block[511 - 8 * k -: 8] = 8'h80;
      end
    end
    w_block[511 - 8 * 56 -: 8] = w_width_eff;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_build) w_state_next = StIssue;
      StIssue: if (i_core_ready) w_state_next = StWait;
      StWait:  if (i_core_digest_valid) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_ready         = 1'b0;
    o_block_valid   = 1'b0;
    o_msg_out_valid = 1'b0;
    unique case (r_state)
      StIdle:  o_ready         = 1'b1;
      StIssue: o_block_valid   = 1'b1;
      StDone:  o_msg_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_block      <= '0;
      r_msg_output <= '0;
    end else begin
      if (w_build) begin
        r_block <= w_block;
      end
      if ((r_state == StWait) && i_core_digest_valid) begin
        r_msg_output <= i_core_digest;
      end
    end
  end

  assign o_block_out  = r_block;
  assign o_msg_output = r_msg_output;

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder; define MD5_PAD_WIDTH_CHECK_EN to exercise width rejection.
`timescale 1ns/1ps

module tb_md5_msg_padder;

  logic         clk;
  logic         rst_n;
  logic [127:0] msg_in;
  logic [7:0]   msg_w;
  logic         msg_v;
  logic         ready;
  logic [511:0] block;
  logic         block_v;
  logic         core_rdy;
  logic [127:0] digest;
  logic         digest_v;
  logic [127:0] msg_out;
  logic         msg_out_v;
`ifdef MD5_PAD_WIDTH_CHECK_EN
  logic         msg_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] DigestA = 128'h0cc175b9c0f1b6a831c399e269772661;

  md5_msg_padder dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_msg_in           (msg_in),
    .i_msg_in_width     (msg_w),
    .i_msg_in_valid     (msg_v),
    .o_ready            (ready),
    .o_block_out        (block),
    .o_block_valid      (block_v),
    .i_core_ready       (core_rdy),
    .i_core_digest      (digest),
    .i_core_digest_valid(digest_v),
    .o_msg_output       (msg_out),
`ifdef MD5_PAD_WIDTH_CHECK_EN
    .o_msg_err          (msg_err),
`endif
    .o_msg_out_valid    (msg_out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single cycle; returns just after the accept edge.
  task automatic send(input logic [127:0] m, input logic [7:0] w);
    msg_in = m;
    msg_w  = w;
    msg_v  = 1'b1;
    tick();
    msg_v  = 1'b0;
  endtask

  // Drain an issued block: transfer, digest pulse, DONE, back in IDLE.
  task automatic finish_txn(input logic [127:0] d);
    core_rdy = 1'b1;
    tick();
    digest   = d;
    digest_v = 1'b1;
    tick();
    digest_v = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL reset_block_valid: got %b expected 0", block_v); end
    n_vec++; if (block !== 512'h0) begin n_err++; $display("FAIL reset_block: got %h expected 0", block); end
    n_vec++; if (msg_out !== 128'h0) begin n_err++; $display("FAIL reset_msg_output: got %h expected 0", msg_out); end
    n_vec++; if (msg_out_v !== 1'b0) begin n_err++; $display("FAIL reset_msg_out_valid: got %b expected 0", msg_out_v); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_char();
    logic [511:0] exp;
    exp = '0;
    exp[511 -: 16] = 16'h6180;
    exp[511 - 8 * 56 -: 8] = 8'h08;
    core_rdy = 1'b1;
    send(128'h61, 8'd8);
    n_vec++; if (block_v !== 1'b1) begin n_err++; $display("FAIL a_block_valid: got %b expected 1", block_v); end
    n_vec++; if (block !== exp) begin n_err++; $display("FAIL a_block: got %h expected %h", block, exp); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL a_ready_busy: got %b expected 0", ready); end
    tick();
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL a_block_valid_drop: got %b expected 0", block_v); end
  endtask

  task automatic test_digest();
    // Continues from test_single_char: DUT is in WAIT.
    digest   = DigestA;
    digest_v = 1'b1;
    tick();
    digest_v = 1'b0;
    n_vec++; if (msg_out_v !== 1'b1) begin n_err++; $display("FAIL dig_valid: got %b expected 1", msg_out_v); end
    n_vec++; if (msg_out !== DigestA) begin n_err++; $display("FAIL dig_value: got %h expected %h", msg_out, DigestA); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL dig_ready_done: got %b expected 0", ready); end
    tick();
    n_vec++; if (msg_out_v !== 1'b0) begin n_err++; $display("FAIL dig_pulse_end: got %b expected 0", msg_out_v); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL dig_ready_back: got %b expected 1", ready); end
  endtask

  task automatic test_boundary_widths();
    logic [511:0] exp;
    exp = '0;
    exp[511 -: 8] = 8'h80;
    send(128'hdeadbeef, 8'd0);
    n_vec++; if (block !== exp) begin n_err++; $display("FAIL w0_block: got %h expected %h", block, exp); end
    finish_txn(128'h1);

    exp = '0;
    exp[511 -: 128] = 128'h6162636465666768696a6b6c6d6e6f70;
    exp[511 - 8 * 16 -: 8] = 8'h80;
    exp[511 - 8 * 56 -: 8] = 8'h80;
    send(128'h6162636465666768696a6b6c6d6e6f70, 8'd128);
    n_vec++; if (block !== exp) begin n_err++; $display("FAIL w128_block: got %h expected %h", block, exp); end
    finish_txn(128'h2);

    exp = '0;
    exp[511 -: 24] = 24'h616280;
    exp[511 - 8 * 56 -: 8] = 8'h10;
    send(128'hffff_6162, 8'd16);
    n_vec++; if (block !== exp) begin n_err++; $display("FAIL w16_block: got %h expected %h", block, exp); end
    finish_txn(128'h3);
    n_vec++; if (msg_out !== 128'h3) begin n_err++; $display("FAIL w16_digest: got %h expected 3", msg_out); end
  endtask

  task automatic test_backpressure();
    logic [511:0] exp;
    exp = '0;
    exp[511 -: 32] = 32'h61626380;
    exp[511 - 8 * 56 -: 8] = 8'h18;
    core_rdy = 1'b0;
    send(128'h616263, 8'd24);
    // A second word offered while busy must be dropped, not queued.
    msg_in = 128'h7a;
    msg_w  = 8'd8;
    msg_v  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (block_v !== 1'b1) begin n_err++; $display("FAIL bp_valid_%0d: got %b expected 1", i, block_v); end
      n_vec++; if (block !== exp) begin n_err++; $display("FAIL bp_stable_%0d: got %h expected %h", i, block, exp); end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_%0d: got %b expected 0", i, ready); end
      tick();
    end
    core_rdy = 1'b1;
    tick();
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL bp_transfer: got %b expected 0", block_v); end
    msg_v = 1'b0;
    digest   = 128'hab;
    digest_v = 1'b1;
    tick();
    digest_v = 1'b0;
    tick();
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL bp_idle: got %b expected 1", ready); end
    tick();
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL bp_no_queue: got %b expected 0", block_v); end
    // Digest pulse in IDLE is ignored.
    digest   = 128'hcd;
    digest_v = 1'b1;
    tick();
    digest_v = 1'b0;
    n_vec++; if (msg_out_v !== 1'b0) begin n_err++; $display("FAIL idle_digest_pulse: got %b expected 0", msg_out_v); end
    n_vec++; if (msg_out !== 128'hab) begin n_err++; $display("FAIL idle_digest_value: got %h expected ab", msg_out); end
  endtask

  task automatic test_reset_mid();
    core_rdy = 1'b1;
    send(128'h61, 8'd8);
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b expected 1", ready); end
    n_vec++; if (block !== 512'h0) begin n_err++; $display("FAIL mid_block: got %h expected 0", block); end
    n_vec++; if (msg_out !== 128'h0) begin n_err++; $display("FAIL mid_msg_output: got %h expected 0", msg_out); end
    tick();
    rst_n    = 1'b1;
    digest   = DigestA;
    digest_v = 1'b1;
    tick();
    digest_v = 1'b0;
    n_vec++; if (msg_out_v !== 1'b0) begin n_err++; $display("FAIL mid_late_valid: got %b expected 0", msg_out_v); end
    n_vec++; if (msg_out !== 128'h0) begin n_err++; $display("FAIL mid_late_value: got %h expected 0", msg_out); end
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL mid_block_valid: got %b expected 0", block_v); end
    tick();
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_idle: got %b expected 1", ready); end
  endtask

  task automatic test_width_check();
`ifdef MD5_PAD_WIDTH_CHECK_EN
    send(128'h0abc, 8'd12);
    n_vec++; if (msg_err !== 1'b1) begin n_err++; $display("FAIL wc_err: got %b expected 1", msg_err); end
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL wc_no_block: got %b expected 0", block_v); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL wc_ready: got %b expected 1", ready); end
    tick();
    n_vec++; if (msg_err !== 1'b0) begin n_err++; $display("FAIL wc_err_pulse: got %b expected 0", msg_err); end
    n_vec++; if (block_v !== 1'b0) begin n_err++; $display("FAIL wc_still_idle: got %b expected 0", block_v); end
    send(128'h61, 8'd136);
    n_vec++; if (msg_err !== 1'b1) begin n_err++; $display("FAIL wc_err_wide: got %b expected 1", msg_err); end
    tick();
`else
    logic [511:0] exp;
    exp = '0;
    exp[511 -: 16] = 16'hbc80;
    exp[511 - 8 * 56 -: 8] = 8'h08;
    core_rdy = 1'b1;
    send(128'h0abc, 8'd12);
    n_vec++; if (block_v !== 1'b1) begin n_err++; $display("FAIL wm_block_valid: got %b expected 1", block_v); end
    n_vec++; if (block !== exp) begin n_err++; $display("FAIL wm_block: got %h expected %h", block, exp); end
    finish_txn(128'h5);
    exp = '0;
    exp[511 -: 128] = 128'h6162636465666768696a6b6c6d6e6f70;
    exp[511 - 8 * 16 -: 8] = 8'h80;
    exp[511 - 8 * 56 -: 8] = 8'h80;
    send(128'h6162636465666768696a6b6c6d6e6f70, 8'd200);
    n_vec++; if (block !== exp) begin n_err++; $display("FAIL wm_clamp: got %h expected %h", block, exp); end
    finish_txn(128'h6);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    msg_in   = '0;
    msg_w    = '0;
    msg_v    = 1'b0;
    core_rdy = 1'b0;
    digest   = '0;
    digest_v = 1'b0;
    test_reset();
    test_single_char();
    test_digest();
    test_boundary_widths();
    test_backpressure();
    test_reset_mid();
    test_width_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
